// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch controller. Owns the program counter and sequences one
// fetch at a time from the instruction memory using a valid/ready request
// channel and a valid-only response channel. The fetched instruction is
// presented to decode over a valid/ready handshake.
//
// Control-flow redirects (trap has priority over branch) can arrive in any
// state. A redirect that lands while a fetch is outstanding makes that fetch
// stale, so its response is discarded in S_DROP.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_req_valid    fetch request valid (asserted in S_REQ)
//   imem_req_ready    instruction memory accepts the request
//   imem_req_addr     fetch address, always the current PC
//   imem_resp_valid   response valid, one per accepted request
//   imem_resp_data    fetched instruction
//   if_valid          instruction available to decode (asserted in S_HOLD)
//   if_ready          decode accepts the instruction
//   if_pc, if_instr   PC and instruction being presented to decode
//   br_valid/target   branch redirect
//   trap_valid/target trap redirect (wins over branch)
//   fetch_count       number of completed decode handshakes (wraps)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               trap_valid,
  input  logic [ADDR_W-1:0]  trap_target,
  output logic [31:0]        fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t              state_q,       state_d;
  logic [ADDR_W-1:0]   pc_q,          pc_d;
  logic [ADDR_W-1:0]   if_pc_q,       if_pc_d;
  logic [INSTR_W-1:0]  if_instr_q,    if_instr_d;
  logic [31:0]         fetch_count_q, fetch_count_d;

  logic                redir;
  logic [ADDR_W-1:0]   redir_raw;
  logic [ADDR_W-1:0]   redir_tgt;

  // Redirect selection: trap wins; targets are forced word-aligned.
  assign redir     = trap_valid | br_valid;
  assign redir_raw = trap_valid ? trap_target : br_target;
  assign redir_tgt = redir_raw & ~ADDR_W'(3);

  // Next-state and datapath logic.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redir) pc_d = redir_tgt;
      end

      S_REQ: begin
        // Responses here are protocol violations and are simply not looked at.
        if (imem_req_ready) begin
          // Request is accepted at the old PC even when redirecting; that
          // fetch is then stale and its response must be dropped.
          state_d = redir ? S_DROP : S_WAIT;
        end
        if (redir) pc_d = redir_tgt;
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          if (redir) begin
            // Response and redirect together: the response is already stale.
            pc_d    = redir_tgt;
            state_d = S_REQ;
          end else begin
            if_instr_d = imem_resp_data;
            if_pc_d    = pc_q;
            pc_d       = pc_q + ADDR_W'(4);
            state_d    = S_HOLD;
          end
        end else if (redir) begin
          pc_d    = redir_tgt;
          state_d = S_DROP;
        end
      end

      S_DROP: begin
        if (imem_resp_valid) state_d = S_REQ;
        if (redir)           pc_d    = redir_tgt;
      end

      S_HOLD: begin
        // if_pc/if_instr keep their values by default while decode stalls.
        if (if_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = S_REQ;
        end
        if (redir) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == S_HOLD);
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed, table-driven bench for fetch_ctrl. Each record holds the inputs
// driven during one clock cycle and the outputs expected during that same
// cycle (all outputs are registered, so they reflect the state entered at the
// previous edge). Inputs are driven on the falling edge and outputs sampled
// 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        if_ready;
    logic        br_valid;
    logic [31:0] br_target;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        e_req_valid;
    logic [31:0] e_req_addr;
    logic        e_if_valid;
    logic [31:0] e_if_pc;
    logic [31:0] e_if_instr;
    logic [31:0] e_fetch_count;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        br_valid;
  logic [31:0] br_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .ADDR_W  (32),
    .RESET_PC(32'h0),
    .INSTR_W (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .br_valid       (br_valid),
    .br_target      (br_target),
    .trap_valid     (trap_valid),
    .trap_target    (trap_target),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Argument order: inputs (rst, rdy, rv, rdata, ifr, bv, btgt, tv, ttgt),
  // then expected outputs (req_valid, req_addr, if_valid, if_pc, if_instr, count).
  function automatic vec_t mk(int r, int rdy, int rv, int rd, int ifr,
                              int bv, int bt, int tv, int tt,
                              int erv, int eaddr, int eiv, int epc,
                              int einstr, int ecnt);
    vec_t v;
    v.rst           = r[0];
    v.req_ready     = rdy[0];
    v.resp_valid    = rv[0];
    v.resp_data     = 32'(rd);
    v.if_ready      = ifr[0];
    v.br_valid      = bv[0];
    v.br_target     = 32'(bt);
    v.trap_valid    = tv[0];
    v.trap_target   = 32'(tt);
    v.e_req_valid   = erv[0];
    v.e_req_addr    = 32'(eaddr);
    v.e_if_valid    = eiv[0];
    v.e_if_pc       = 32'(epc);
    v.e_if_instr    = 32'(einstr);
    v.e_fetch_count = 32'(ecnt);
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst             = v.rst;
    imem_req_ready  = v.req_ready;
    imem_resp_valid = v.resp_valid;
    imem_resp_data  = v.resp_data;
    if_ready        = v.if_ready;
    br_valid        = v.br_valid;
    br_target       = v.br_target;
    trap_valid      = v.trap_valid;
    trap_target     = v.trap_target;
    #1;
    check({tag, ".req_valid"},   32'(imem_req_valid), 32'(v.e_req_valid));
    check({tag, ".req_addr"},    imem_req_addr,       v.e_req_addr);
    check({tag, ".if_valid"},    32'(if_valid),       32'(v.e_if_valid));
    check({tag, ".if_pc"},       if_pc,               v.e_if_pc);
    check({tag, ".if_instr"},    if_instr,            v.e_if_instr);
    check({tag, ".fetch_count"}, fetch_count,         v.e_fetch_count);
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    //                 r rdy rv rdata   ifr bv btgt    tv ttgt     erv eaddr   eiv epc     einstr  cnt
    // Zero-wait fetches 0x0, 0x4, 0x8 with decode always ready.
    tbl.push_back(mk(0, 1, 0, 0,       1, 0, 0,      0, 0,       0, 'h000, 0, 'h000, 0,      0)); // 0 IDLE
    tbl.push_back(mk(0, 1, 0, 0,       1, 0, 0,      0, 0,       1, 'h000, 0, 'h000, 0,      0)); // 1 REQ
    tbl.push_back(mk(0, 1, 1, 'hA0,    1, 0, 0,      0, 0,       0, 'h000, 0, 'h000, 0,      0)); // 2 WAIT
    tbl.push_back(mk(0, 1, 0, 0,       1, 0, 0,      0, 0,       0, 'h004, 1, 'h000, 'hA0,   0)); // 3 HOLD
    tbl.push_back(mk(0, 1, 0, 0,       1, 0, 0,      0, 0,       1, 'h004, 0, 'h000, 'hA0,   1)); // 4 REQ
    tbl.push_back(mk(0, 1, 1, 'hA1,    1, 0, 0,      0, 0,       0, 'h004, 0, 'h000, 'hA0,   1)); // 5 WAIT
    tbl.push_back(mk(0, 1, 0, 0,       1, 0, 0,      0, 0,       0, 'h008, 1, 'h004, 'hA1,   1)); // 6 HOLD
    tbl.push_back(mk(0, 1, 0, 0,       1, 0, 0,      0, 0,       1, 'h008, 0, 'h004, 'hA1,   2)); // 7 REQ
    tbl.push_back(mk(0, 1, 1, 'hA2,    1, 0, 0,      0, 0,       0, 'h008, 0, 'h004, 'hA1,   2)); // 8 WAIT
    tbl.push_back(mk(0, 1, 0, 0,       1, 0, 0,      0, 0,       0, 'h00C, 1, 'h008, 'hA2,   2)); // 9 HOLD
    // Memory not ready for 5 cycles: request held at 0xC.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0,     1, 0, 0,      0, 0,       1, 'h00C, 0, 'h008, 'hA2,   3)); // 10-14 REQ stall
    tbl.push_back(mk(0, 1, 0, 0,       1, 0, 0,      0, 0,       1, 'h00C, 0, 'h008, 'hA2,   3)); // 15 REQ accept
    tbl.push_back(mk(0, 0, 1, 'hA3,    0, 0, 0,      0, 0,       0, 'h00C, 0, 'h008, 'hA2,   3)); // 16 WAIT
    // Decode stalls for 4 cycles: presented data stable, no new request.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 0, 0,     0, 0, 0,      0, 0,       0, 'h010, 1, 'h00C, 'hA3,   3)); // 17-20 HOLD stall
    tbl.push_back(mk(0, 0, 0, 0,       1, 0, 0,      0, 0,       0, 'h010, 1, 'h00C, 'hA3,   3)); // 21 HOLD accept
    tbl.push_back(mk(0, 1, 0, 0,       0, 0, 0,      0, 0,       1, 'h010, 0, 'h00C, 'hA3,   4)); // 22 REQ
    // Branch in WAIT before the response: response dropped, refetch 0x100.
    tbl.push_back(mk(0, 0, 0, 0,       0, 1, 'h100,  0, 0,       0, 'h010, 0, 'h00C, 'hA3,   4)); // 23 WAIT br
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      0, 0,       0, 'h100, 0, 'h00C, 'hA3,   4)); // 24 DROP
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      0, 0,       0, 'h100, 0, 'h00C, 'hA3,   4)); // 25 DROP
    tbl.push_back(mk(0, 0, 1, 'hDEAD,  0, 0, 0,      0, 0,       0, 'h100, 0, 'h00C, 'hA3,   4)); // 26 DROP resp
    // Trap beats branch; trap target low bits masked (0x203 -> 0x200).
    tbl.push_back(mk(0, 0, 0, 0,       0, 1, 'h300,  1, 'h203,   1, 'h100, 0, 'h00C, 'hA3,   4)); // 27 REQ redirect
    tbl.push_back(mk(0, 1, 0, 0,       0, 0, 0,      0, 0,       1, 'h200, 0, 'h00C, 'hA3,   4)); // 28 REQ
    tbl.push_back(mk(0, 0, 1, 'hB0,    0, 0, 0,      0, 0,       0, 'h200, 0, 'h00C, 'hA3,   4)); // 29 WAIT
    // Branch in HOLD without decode accept: no count, refetch 0x500.
    tbl.push_back(mk(0, 0, 0, 0,       0, 1, 'h500,  0, 0,       0, 'h204, 1, 'h200, 'hB0,   4)); // 30 HOLD br
    tbl.push_back(mk(0, 1, 0, 0,       0, 0, 0,      0, 0,       1, 'h500, 0, 'h200, 'hB0,   4)); // 31 REQ
    // Response and trap together in WAIT: response discarded.
    tbl.push_back(mk(0, 0, 1, 'hBAD,   0, 0, 0,      1, 'h600,   0, 'h500, 0, 'h200, 'hB0,   4)); // 32 WAIT
    tbl.push_back(mk(0, 1, 0, 0,       0, 0, 0,      0, 0,       1, 'h600, 0, 'h200, 'hB0,   4)); // 33 REQ
    tbl.push_back(mk(0, 0, 1, 'hB2,    0, 0, 0,      0, 0,       0, 'h600, 0, 'h200, 'hB0,   4)); // 34 WAIT
    // Decode accept plus branch in HOLD: count increments, PC redirects.
    tbl.push_back(mk(0, 0, 0, 0,       1, 1, 'h700,  0, 0,       0, 'h604, 1, 'h600, 'hB2,   4)); // 35 HOLD
    // Accepted together with a branch: fetch at 0x700 is stale.
    tbl.push_back(mk(0, 1, 0, 0,       0, 1, 'h800,  0, 0,       1, 'h700, 0, 'h600, 'hB2,   5)); // 36 REQ
    tbl.push_back(mk(0, 0, 1, 'hBAD,   0, 0, 0,      0, 0,       0, 'h800, 0, 'h600, 'hB2,   5)); // 37 DROP
    // Stray response in REQ is ignored.
    tbl.push_back(mk(0, 0, 1, 'hBAD,   0, 0, 0,      0, 0,       1, 'h800, 0, 'h600, 'hB2,   5)); // 38 REQ
    tbl.push_back(mk(0, 1, 0, 0,       0, 0, 0,      0, 0,       1, 'h800, 0, 'h600, 'hB2,   5)); // 39 REQ accept

    // Reset in WAIT at PC 0x1C, stale responses afterwards, then PC wrap.
    seq.push_back(mk(0, 0, 0, 0,       0, 1, 'h1F,   0, 0,       0, 'h800, 0, 'h600, 'hB2,   5)); // WAIT br 0x1C
    seq.push_back(mk(0, 0, 1, 'hBAD,   0, 0, 0,      0, 0,       0, 'h01C, 0, 'h600, 'hB2,   5)); // DROP resp
    seq.push_back(mk(0, 1, 0, 0,       0, 0, 0,      0, 0,       1, 'h01C, 0, 'h600, 'hB2,   5)); // REQ accept
    seq.push_back(mk(1, 0, 0, 0,       0, 0, 0,      0, 0,       0, 'h01C, 0, 'h600, 'hB2,   5)); // WAIT, rst
    seq.push_back(mk(0, 0, 1, 'hBAD,   0, 0, 0,      0, 0,       0, 'h000, 0, 'h000, 0,      0)); // IDLE stale resp
    seq.push_back(mk(0, 0, 1, 'hBAD,   0, 0, 0,      0, 0,       1, 'h000, 0, 'h000, 0,      0)); // REQ stale resp
    seq.push_back(mk(0, 1, 0, 0,       0, 0, 0,      0, 0,       1, 'h000, 0, 'h000, 0,      0)); // REQ accept
    seq.push_back(mk(0, 0, 1, 'hC0,    0, 0, 0,      0, 0,       0, 'h000, 0, 'h000, 0,      0)); // WAIT
    seq.push_back(mk(0, 0, 0, 0,       0, 1, 'hFFFFFFFC, 0, 0,   0, 'h004, 1, 'h000, 'hC0,   0)); // HOLD br
    seq.push_back(mk(0, 1, 0, 0,       0, 0, 0,      0, 0,       1, 'hFFFFFFFC, 0, 'h000, 'hC0, 0)); // REQ
    seq.push_back(mk(0, 0, 1, 'hC1,    0, 0, 0,      0, 0,       0, 'hFFFFFFFC, 0, 'h000, 'hC0, 0)); // WAIT
    seq.push_back(mk(0, 0, 0, 0,       1, 0, 0,      0, 0,       0, 'h000, 1, 'hFFFFFFFC, 'hC1, 0)); // HOLD wrapped
    seq.push_back(mk(0, 0, 0, 0,       0, 0, 0,      0, 0,       1, 'h000, 0, 'hFFFFFFFC, 'hC1, 1)); // REQ at 0x0

    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if_ready        = 1'b0;
    br_valid        = 1'b0;
    br_target       = '0;
    trap_valid      = 1'b0;
    trap_target     = '0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    foreach (seq[i]) apply(seq[i], $sformatf("seq%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
